// File: rtl/fsm_ij_array.sv
// fsm_ij_array
//   NCH independent copies of the four-state A/B/C/D i/j Moore controller.
//   Each channel has an advance enable, a synchronous clear to A, a
//   saturating dwell counter and a one-cycle pulse after each state change.
//
// Parameters
//   NCH    number of independent channels (>= 1)
//   CNT_W  width of each per-channel dwell counter (>= 2)
//
// Ports
//   clk      in   1          rising-edge clock
//   rstn     in   1          asynchronous active-low reset
//   en       in   NCH        per-channel advance enable (0 freezes the channel)
//   clr      in   NCH        per-channel synchronous clear to A (beats en)
//   i, j     in   NCH        per-channel transition inputs
//   x, y     out  NCH        per-channel Moore outputs
//   state_o  out  2*NCH      channel k state code at [2k+1:2k]
//   dwell    out  CNT_W*NCH  channel k cycles in current state at [CNT_W*(k+1)-1:CNT_W*k]
//   changed  out  NCH        channel k high for one cycle after a state change
module fsm_ij_array #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       clr,
  input  logic [NCH-1:0]       i,
  input  logic [NCH-1:0]       j,
  output logic [NCH-1:0]       x,
  output logic [NCH-1:0]       y,
  output logic [2*NCH-1:0]     state_o,
  output logic [CNT_W*NCH-1:0] dwell,
  output logic [NCH-1:0]       changed
);

  typedef enum logic [1:0] {
    ST_A = 2'b00,
    ST_B = 2'b01,
    ST_C = 2'b10,
    ST_D = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_MAX = '1;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      state_t           state_reg, state_next, step_next;
      logic [CNT_W-1:0] dwell_reg, dwell_next;
      logic             changed_reg, changed_next;

      // Where the channel would go if it were allowed to advance this cycle.
      always_comb begin
        step_next = state_reg;
        case (state_reg)
          ST_A:    step_next = i[gi] ? ST_B : ST_A;
          ST_B:    step_next = i[gi] ? ST_C : ST_D;
          ST_C:    step_next = i[gi] ? ST_B : (j[gi] ? ST_C : ST_D);
          ST_D:    step_next = i[gi] ? ST_D : (j[gi] ? ST_C : ST_A);
          default: step_next = ST_A;
        endcase
      end

      // Clear beats enable; a frozen channel keeps state and dwell.
      always_comb begin
        state_next   = state_reg;
        dwell_next   = dwell_reg;
        changed_next = 1'b0;
        if (clr[gi]) begin
          state_next = ST_A;
          dwell_next = '0;
        end else if (en[gi]) begin
          if (step_next != state_reg) begin
            state_next   = step_next;
            dwell_next   = '0;
            changed_next = 1'b1;
          end else if (dwell_reg != DWELL_MAX) begin
            // Self-loop: count time spent here, sticking at all-ones.
            dwell_next = dwell_reg + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          state_reg   <= ST_A;
          dwell_reg   <= '0;
          changed_reg <= 1'b0;
        end else begin
          state_reg   <= state_next;
          dwell_reg   <= dwell_next;
          changed_reg <= changed_next;
        end
      end

      // Decode from the register only: A=11, B=01, C=10, D=10.
      assign x[gi] = (state_reg != ST_B);
      assign y[gi] = ~state_reg[1];

      assign state_o[2*gi +: 2]         = state_reg;
      assign dwell[CNT_W*gi +: CNT_W]   = dwell_reg;
      assign changed[gi]                = changed_reg;
    end
  endgenerate

endmodule
